// File: rtl/audio_dac_serializer_pkg.sv
// rtl/audio_dac_serializer_pkg.sv - shared audio parameters and helpers
package audio_dac_serializer_pkg;

    localparam int AUD_DATA_WIDTH  = 16;
    localparam int AUD_FIFO_DEPTH  = 4;
    localparam int AUD_REF_CLK     = 18_432_000;
    localparam int AUD_SAMPLE_RATE = 48_000;

    typedef logic [7:0] ur_count_t;

    function automatic ur_count_t sat_inc(input ur_count_t v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - stereo frame buffer with registered ready and level
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     CLK_18_4,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [WIDTH-1:0]         m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic             push;
    logic             pop;

    assign push     = s_tvalid & s_tready;
    assign pop      = m_tready & m_tvalid;
    assign m_tvalid = (level != '0);
    assign m_tdata  = mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (push && !pop)
            level_next = level + 1'b1;
        else if (pop && !push)
            level_next = level - 1'b1;
    end

    // Ready is registered from the next level so it never depends on s_tvalid.
    always_ff @(posedge CLK_18_4 or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            s_tready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level    <= level_next;
            s_tready <= (level_next < LW'(DEPTH));
        end
    end

    always_ff @(posedge CLK_18_4) begin
        if (push)
            mem[wr_ptr] <= s_tdata;
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - left-justified stereo DAC serializer with frame FIFO
module audio_dac_serializer
    import audio_dac_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = AUD_DATA_WIDTH,
    parameter int FIFO_DEPTH = AUD_FIFO_DEPTH
) (
    input  logic                          CLK_18_4,
    input  logic                          RST,
    input  logic                          AUD_BCK,
    input  logic                          AUD_LRCK,
    input  logic [DATA_WIDTH-1:0]         IN_L,
    input  logic [DATA_WIDTH-1:0]         IN_R,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    output logic                          AUD_DACDAT,
    output logic                          UNDERRUN,
    output ur_count_t                     UNDERRUN_CNT,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic                    bck_q, bck_q2, lrck_q, lrck_q2, primed;
    logic                    bck_fall, lrck_rise, lrck_fall;
    logic [2*DATA_WIDTH-1:0] frame;
    logic                    frame_avail;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   right_hold;
    logic [CW-1:0]           bit_cnt;

    assign bck_fall   = bck_q2 & ~bck_q;
    assign lrck_rise  = lrck_q & ~lrck_q2;
    assign lrck_fall  = lrck_q2 & ~lrck_q;
    assign AUD_DACDAT = shift_reg[DATA_WIDTH-1];

    audio_sample_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK_18_4 (CLK_18_4),
        .RST      (RST),
        .s_tdata  ({IN_L, IN_R}),
        .s_tvalid (IN_VALID),
        .s_tready (IN_READY),
        .m_tdata  (frame),
        .m_tvalid (frame_avail),
        .m_tready (lrck_rise),
        .level    (FIFO_LEVEL)
    );

    // First cycle after reset seeds both stages so a high LRCK is not seen as a frame start.
    always_ff @(posedge CLK_18_4 or negedge RST) begin
        if (!RST) begin
            bck_q   <= 1'b0;
            bck_q2  <= 1'b0;
            lrck_q  <= 1'b0;
            lrck_q2 <= 1'b0;
            primed  <= 1'b0;
        end else begin
            primed  <= 1'b1;
            bck_q   <= AUD_BCK;
            lrck_q  <= AUD_LRCK;
            bck_q2  <= primed ? bck_q  : AUD_BCK;
            lrck_q2 <= primed ? lrck_q : AUD_LRCK;
        end
    end

    always_ff @(posedge CLK_18_4 or negedge RST) begin
        if (!RST) begin
            shift_reg    <= '0;
            right_hold   <= '0;
            bit_cnt      <= '0;
            UNDERRUN     <= 1'b0;
            UNDERRUN_CNT <= '0;
        end else begin
            UNDERRUN <= 1'b0;
            if (lrck_rise) begin
                bit_cnt <= '0;
                if (frame_avail) begin
                    shift_reg  <= frame[2*DATA_WIDTH-1:DATA_WIDTH];
                    right_hold <= frame[DATA_WIDTH-1:0];
                end else begin
                    shift_reg    <= '0;
                    right_hold   <= '0;
                    UNDERRUN     <= 1'b1;
                    UNDERRUN_CNT <= sat_inc(UNDERRUN_CNT);
                end
            end else if (lrck_fall) begin
                shift_reg <= right_hold;
                bit_cnt   <= '0;
            end else if (bck_fall) begin
                if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                    shift_reg <= '0;
                end else begin
                    shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb/tb_audio_dac_serializer.sv - directed scoreboard bench for audio_dac_serializer
module tb_audio_dac_serializer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic        CLK_18_4 = 1'b0;
    logic        RST;
    logic        AUD_BCK = 1'b0;
    logic        AUD_LRCK = 1'b0;
    logic [DW-1:0] IN_L = '0;
    logic [DW-1:0] IN_R = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        AUD_DACDAT;
    logic        UNDERRUN;
    logic [7:0]  UNDERRUN_CNT;
    logic [2:0]  FIFO_LEVEL;

    int errors = 0;
    int checks = 0;
    int ph = 0;
    int bp = 12;
    int exp_cnt = 0;
    int ur_pulses = 0;
    logic [31:0] model_q [$];
    logic        exp_bits [$];
    logic        cur_exp = 1'b0;

    audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK_18_4     (CLK_18_4),
        .RST          (RST),
        .AUD_BCK      (AUD_BCK),
        .AUD_LRCK     (AUD_LRCK),
        .IN_L         (IN_L),
        .IN_R         (IN_R),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .AUD_DACDAT   (AUD_DACDAT),
        .UNDERRUN     (UNDERRUN),
        .UNDERRUN_CNT (UNDERRUN_CNT),
        .FIFO_LEVEL   (FIFO_LEVEL)
    );

    always #27 CLK_18_4 = ~CLK_18_4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_clocks();
        AUD_BCK  = (ph % bp) >= (bp / 2);
        AUD_LRCK = ph < 16 * bp;
    endtask

    task automatic step();
        logic        rdy;
        logic        vld;
        logic        rst_edge;
        logic        ur_ev;
        logic [31:0] din;
        logic [31:0] f;
        rdy      = IN_READY;
        vld      = IN_VALID;
        din      = {IN_L, IN_R};
        rst_edge = RST;
        @(posedge CLK_18_4);
        #1;
        ur_ev = 1'b0;
        if (!rst_edge) begin
            model_q.delete();
            exp_bits.delete();
            cur_exp = 1'b0;
            exp_cnt = 0;
        end else begin
            if (ph == 1) begin
                if (model_q.size() > 0) begin
                    f = model_q.pop_front();
                end else begin
                    f = '0;
                    ur_ev = 1'b1;
                    exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
                end
                for (int i = 31; i >= 0; i--) exp_bits.push_back(f[i]);
            end
            if (vld && rdy) model_q.push_back(din);
        end
        ph = (ph + 1) % (32 * bp);
        drive_clocks();
        if (ph % bp == 2) cur_exp = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'b0;
        if (ph % bp == 2 || ph % bp == 1) chk("dacdat", AUD_DACDAT, cur_exp);
        chk("underrun", UNDERRUN, ur_ev);
        chk("underrun_cnt", UNDERRUN_CNT, exp_cnt);
        chk("fifo_level", FIFO_LEVEL, model_q.size());
        chk("in_ready", IN_READY, rst_edge && (model_q.size() < DEPTH));
        if (UNDERRUN === 1'b1) ur_pulses++;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int   n;
        logic ok;
        n = 0;
        IN_L = l;
        IN_R = r;
        IN_VALID = 1'b1;
        do begin
            ok = IN_READY;
            step();
            n++;
        end while (ok !== 1'b1 && n < 32 * bp + 10);
        IN_VALID = 1'b0;
        chk("push_accept", ok, 1);
    endtask

    task automatic wait_ph(input int target);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (ph != target && n < 32 * bp + 2);
        chk("wait_ph", ph, target);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_dacdat", AUD_DACDAT, 0);
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_underrun", UNDERRUN, 0);
        chk("rst_underrun_cnt", UNDERRUN_CNT, 0);
        chk("rst_fifo_level", FIFO_LEVEL, 0);
    endtask

    initial begin
        RST = 1'b1;
        bp  = 12;
        ph  = 300;
        drive_clocks();
        #2;
        RST = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (3) step();
        chk_reset_outputs();

        RST = 1'b1;
        step();
        chk("ready_after_release", IN_READY, 1);
        ur_pulses = 0;

        // One frame of A5C3/0F0F, then three starved frames
        push(16'hA5C3, 16'h0F0F);
        wait_ph(2);
        repeat (3) wait_ph(2);
        wait_ph(200);
        chk("starve_cnt", UNDERRUN_CNT, 3);
        chk("starve_pulses", ur_pulses, 3);

        // Fill to depth; the fifth frame waits for the next frame start
        push(16'h1234, 16'h5678);
        push(16'h8000, 16'h7FFF);
        push(16'hFFFF, 16'h0001);
        push(16'h0F1E, 16'hC3A5);
        chk("full_ready", IN_READY, 0);
        chk("full_level", FIFO_LEVEL, 4);
        push(16'hDEAD, 16'hBEEF);
        chk("fifth_accept_ph", ph, 3);
        chk("fifth_level", FIFO_LEVEL, 4);
        repeat (5) wait_ph(2);
        chk("drained_level", FIFO_LEVEL, 0);

        // Push coincident with an empty frame start
        wait_ph(1);
        push(16'hFFFF, 16'h8001);
        chk("collide_underrun", UNDERRUN, 1);
        chk("collide_level", FIFO_LEVEL, 1);
        wait_ph(2);
        wait_ph(100);

        // Reset mid-left with two frames queued
        push(16'h4444, 16'h2222);
        push(16'h3333, 16'h1111);
        chk("pre_reset_level", FIFO_LEVEL, 2);
        step();
        RST = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (3) step();
        RST = 1'b1;
        wait_ph(2);
        wait_ph(200);
        chk("post_reset_cnt", UNDERRUN_CNT, 1);

        // Saturation with a faster audio clock
        RST = 1'b0;
        #1;
        bp = 4;
        ph = 40;
        drive_clocks();
        repeat (3) step();
        RST = 1'b1;
        step();
        ur_pulses = 0;
        repeat (300) wait_ph(2);
        chk("sat_pulses", ur_pulses, 300);
        chk("sat_cnt", UNDERRUN_CNT, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
